ram_apb_arbiter: RTL and testbench

Two-requester APB master front end that shares the RAM APB slave port (ram_apb_s05 slave behind ram_s05_wrapper_top) between two on-chip clients, e.g. the PUF engine and the host bridge. Each requester issues a simple held-request transaction. The block arbitrates round-robin, runs the APB SETUP/ACCESS protocol with wait states, and returns read data, error status and a one-cycle acknowledge. A wait-state timeout guarantees that a hung slave never locks the requesters out.

---
 rtl/ram_apb_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_ram_apb_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_apb_arbiter.sv
// rtl/ram_apb_arbiter.sv - two-requester round-robin APB master for the shared RAM slave port

module ram_apb_arbiter #(
   parameter int APB_ADDR_WIDTH   = 32,
   parameter int APB_DATA_WIDTH   = 32,
   parameter int APB_STROBE_WIDTH = 4,
   parameter int TIMEOUT          = 16
) (
   input  logic                        PCLK,
   input  logic                        PRESETn,

   input  logic                        r0_req,
   input  logic [APB_ADDR_WIDTH-1:0]   r0_addr,
   input  logic [APB_DATA_WIDTH-1:0]   r0_wdata,
   input  logic                        r0_write,
   input  logic [APB_STROBE_WIDTH-1:0] r0_strb,
   input  logic [2:0]                  r0_prot,
   output logic                        r0_ack,
   output logic [APB_DATA_WIDTH-1:0]   r0_rdata,
   output logic                        r0_err,

   input  logic                        r1_req,
   input  logic [APB_ADDR_WIDTH-1:0]   r1_addr,
   input  logic [APB_DATA_WIDTH-1:0]   r1_wdata,
   input  logic                        r1_write,
   input  logic [APB_STROBE_WIDTH-1:0] r1_strb,
   input  logic [2:0]                  r1_prot,
   output logic                        r1_ack,
   output logic [APB_DATA_WIDTH-1:0]   r1_rdata,
   output logic                        r1_err,

   output logic                        busy,
   output logic                        grant_id,

   output logic [APB_ADDR_WIDTH-1:0]   PADDR,
   output logic [APB_DATA_WIDTH-1:0]   PWDATA,
   output logic [2:0]                  PPROT,
   output logic [APB_STROBE_WIDTH-1:0] PSTRB,
   output logic                        PWRITE,
   output logic                        PSEL,
   output logic                        PENABLE,
   input  logic                        PREADY,
   input  logic                        PSLVERR,
   input  logic [APB_DATA_WIDTH-1:0]   PRDATA
);

   // Wait counter must hold the value TIMEOUT; keep at least one bit when the timeout is disabled.
   localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WCW-1:0] WC_LIMIT = WCW'(TIMEOUT);
   localparam logic [WCW-1:0] WC_MAX   = {WCW{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t                      state_q;
   state_t                      state_d;
   logic                        last_grant_q;
   logic [WCW-1:0]              wait_cnt_q;
   logic                        timeout_hit;
   logic                        access_end;

   logic                        win_id;
   logic [APB_ADDR_WIDTH-1:0]   win_addr;
   logic [APB_DATA_WIDTH-1:0]   win_wdata;
   logic                        win_write;
   logic [APB_STROBE_WIDTH-1:0] win_strb;
   logic [2:0]                  win_prot;

   logic [APB_DATA_WIDTH-1:0]   rsp_rdata;
   logic                        rsp_err;

   // Round-robin pick: a lone requester wins, on contention the one not served last wins.
   always_comb begin
      win_id = 1'b0;
      if (r0_req && r1_req) begin
         win_id = ~last_grant_q;
      end else begin
         win_id = r1_req;
      end
      win_addr  = win_id ? r1_addr  : r0_addr;
      win_wdata = win_id ? r1_wdata : r0_wdata;
      win_write = win_id ? r1_write : r0_write;
      win_strb  = win_id ? r1_strb  : r0_strb;
      win_prot  = win_id ? r1_prot  : r0_prot;
   end

   // Next-state logic plus the state-decoded APB handshake, ack and busy outputs.
   always_comb begin
      state_d     = state_q;
      timeout_hit = 1'b0;
      PSEL        = 1'b0;
      PENABLE     = 1'b0;
      busy        = 1'b1;
      r0_ack      = 1'b0;
      r1_ack      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (r0_req || r1_req) begin
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            PSEL    = 1'b1;
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
            if (PREADY) begin
               state_d = ST_DONE;
            end else if ((TIMEOUT != 0) && (wait_cnt_q == WC_LIMIT)) begin
               state_d     = ST_DONE;
               timeout_hit = 1'b1;
            end
         end
         ST_DONE: begin
            r0_ack  = ~grant_id;
            r1_ack  = grant_id;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign access_end = (state_q == ST_ACCESS) && (state_d == ST_DONE);
   // A timed-out transfer reports an error with zero data; writes never return data.
   assign rsp_rdata  = (timeout_hit || PWRITE) ? '0 : PRDATA;
   assign rsp_err    = timeout_hit | PSLVERR;

   // State register, round-robin pointer and saturating wait-state counter.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         wait_cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_DONE) begin
            last_grant_q <= grant_id;
         end
         if ((state_q == ST_IDLE) && (state_d == ST_SETUP)) begin
            wait_cnt_q <= '0;
         end else if ((state_q == ST_ACCESS) && (state_d == ST_ACCESS) &&
                      (wait_cnt_q != WC_MAX)) begin
            wait_cnt_q <= wait_cnt_q + WCW'(1);
         end
      end
   end

   // Latch the winner's request into the APB output registers; they hold until the next grant.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         grant_id <= 1'b0;
         PADDR    <= '0;
         PWDATA   <= '0;
         PWRITE   <= 1'b0;
         PSTRB    <= '0;
         PPROT    <= '0;
      end else if ((state_q == ST_IDLE) && (r0_req || r1_req)) begin
         grant_id <= win_id;
         PADDR    <= win_addr;
         PWDATA   <= win_wdata;
         PWRITE   <= win_write;
         PSTRB    <= win_write ? win_strb : '0;
         PPROT    <= win_prot;
      end
   end

   // Capture the response into the granted requester's result registers so it is valid in DONE.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r0_rdata <= '0;
         r0_err   <= 1'b0;
         r1_rdata <= '0;
         r1_err   <= 1'b0;
      end else if (access_end) begin
         if (grant_id) begin
            r1_rdata <= rsp_rdata;
            r1_err   <= rsp_err;
         end else begin
            r0_rdata <= rsp_rdata;
            r0_err   <= rsp_err;
         end
      end
   end

endmodule

// File: tb/tb_ram_apb_arbiter.sv
// tb/tb_ram_apb_arbiter.sv - self-checking bench for ram_apb_arbiter

module tb_ram_apb_arbiter;

   localparam int TO = 16;

   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b0;
   logic        r0_req = 1'b0, r1_req = 1'b0;
   logic [31:0] r0_addr = '0, r1_addr = '0;
   logic [31:0] r0_wdata = '0, r1_wdata = '0;
   logic        r0_write = 1'b0, r1_write = 1'b0;
   logic [3:0]  r0_strb = '0, r1_strb = '0;
   logic [2:0]  r0_prot = '0, r1_prot = '0;
   logic        r0_ack, r1_ack, r0_err, r1_err, busy, grant_id;
   logic [31:0] r0_rdata, r1_rdata;
   logic [31:0] PADDR, PWDATA;
   logic [2:0]  PPROT;
   logic [3:0]  PSTRB;
   logic        PWRITE, PSEL, PENABLE;
   logic        PREADY = 1'b0, PSLVERR = 1'b0;
   logic [31:0] PRDATA = '0;

   int total = 0;
   int bad   = 0;

   // slave knobs and storage
   int          sl_waits = 0;
   bit          sl_err   = 1'b0;
   int          sl_cnt   = 0;
   logic [31:0] slv_mem [16] = '{default: '0};
   // reference model storage
   logic [31:0] ref_mem [16] = '{default: '0};

   ram_apb_arbiter #(
      .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .APB_STROBE_WIDTH(4), .TIMEOUT(TO)
   ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .r0_req(r0_req), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_write(r0_write),
      .r0_strb(r0_strb), .r0_prot(r0_prot), .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
      .r1_req(r1_req), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_write(r1_write),
      .r1_strb(r1_strb), .r1_prot(r1_prot), .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
      .busy(busy), .grant_id(grant_id),
      .PADDR(PADDR), .PWDATA(PWDATA), .PPROT(PPROT), .PSTRB(PSTRB), .PWRITE(PWRITE),
      .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
   );

   always #5 PCLK = ~PCLK;

   // APB slave: holds PREADY low for sl_waits ACCESS cycles, writes honour PSTRB
   always @(negedge PCLK) begin : slave
      logic [31:0] m;
      if (PSEL && PENABLE) begin
         if (sl_cnt < sl_waits) begin
            PREADY <= 1'b0;
            sl_cnt <= sl_cnt + 1;
         end else begin
            PREADY  <= 1'b1;
            PSLVERR <= sl_err;
            PRDATA  <= PWRITE ? 32'hA5A5_5A5A : slv_mem[PADDR[5:2]];
            if (PWRITE && !sl_err) begin
               m = slv_mem[PADDR[5:2]];
               for (int b = 0; b < 4; b++)
                  if (PSTRB[b]) m[8*b +: 8] = PWDATA[8*b +: 8];
               slv_mem[PADDR[5:2]] <= m;
            end
         end
      end else begin
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         PRDATA  <= '0;
         sl_cnt  <= 0;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // reference model: byte-merge write at the requester level
   function automatic void model_write(input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic [3:0] strb);
      for (int b = 0; b < 4; b++)
         if (strb[b]) ref_mem[addr[5:2]][8*b +: 8] = wdata[8*b +: 8];
   endfunction

   // one transaction from requester id; called at posedge+1 with the DUT in IDLE
   task automatic run_txn(input string nm, input bit id, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                          input int waits, input bit serr, input int exp_lat,
                          input logic [31:0] exp_rdata, input bit exp_err);
      int setup_c = -1, ack_c = -1;
      bit stable_ok = 1, pen_ok = 1, busy_ok = 1, other_ack = 0, dsel = 1;
      logic [31:0] s_addr = '0, s_wdata = '0, got_rd = '0;
      logic [3:0]  s_strb = '0;
      logic [2:0]  s_prot = '0;
      logic        s_write = 1'b0, got_err = 1'b0;
      logic [32:0] other_before, other_after;
      sl_waits = waits;
      sl_err   = serr;
      other_before = id ? {r0_err, r0_rdata} : {r1_err, r1_rdata};
      if (!id) begin
         r0_addr = addr; r0_wdata = wdata; r0_write = wr; r0_strb = strb; r0_prot = prot; r0_req = 1;
      end else begin
         r1_addr = addr; r1_wdata = wdata; r1_write = wr; r1_strb = strb; r1_prot = prot; r1_req = 1;
      end
      for (int n = 0; n < 60; n++) begin
         @(negedge PCLK);
         if (PSEL && setup_c < 0) begin
            setup_c = n;
            s_addr = PADDR; s_wdata = PWDATA; s_strb = PSTRB; s_prot = PPROT; s_write = PWRITE;
            if (PENABLE) pen_ok = 0;
         end else if (PSEL) begin
            if ({PADDR, PWDATA, PSTRB, PPROT, PWRITE} !== {s_addr, s_wdata, s_strb, s_prot, s_write})
               stable_ok = 0;
            if (!PENABLE) pen_ok = 0;
         end else if (PENABLE) begin
            pen_ok = 0;
         end
         if (n == 0 && busy) busy_ok = 0;
         if (n >= 1 && !busy) busy_ok = 0;
         if (id ? r0_ack : r1_ack) other_ack = 1;
         if (id ? r1_ack : r0_ack) begin
            ack_c   = n;
            got_rd  = id ? r1_rdata : r0_rdata;
            got_err = id ? r1_err : r0_err;
            dsel    = PSEL | PENABLE;
            break;
         end
         @(posedge PCLK); #1;
      end
      @(posedge PCLK); #1;
      if (!id) r0_req = 0; else r1_req = 0;
      @(negedge PCLK);
      chk({nm, " ack_one_cycle"}, r0_ack | r1_ack, 0);
      other_after = id ? {r0_err, r0_rdata} : {r1_err, r1_rdata};
      chk({nm, " setup_cycle"}, setup_c, 1);
      chk({nm, " ack_cycle"}, ack_c, exp_lat);
      chk({nm, " rdata"}, got_rd, exp_rdata);
      chk({nm, " err"}, got_err, exp_err);
      chk({nm, " other_ack"}, other_ack, 0);
      chk({nm, " other_hold"}, other_after, other_before);
      chk({nm, " apb_stable"}, stable_ok, 1);
      chk({nm, " penable"}, pen_ok, 1);
      chk({nm, " busy"}, busy_ok, 1);
      chk({nm, " psel_done"}, dsel, 0);
      chk({nm, " paddr"}, s_addr, addr);
      chk({nm, " pwrite"}, s_write, wr);
      chk({nm, " pstrb"}, s_strb, wr ? strb : 4'h0);
      chk({nm, " pprot"}, s_prot, prot);
      if (wr) chk({nm, " pwdata"}, s_wdata, wdata);
      if (wr && !serr && waits <= TO) model_write(addr, wdata, strb);
      @(posedge PCLK); #1;
   endtask

   // both requesters hold reads; expect alternating grants starting with r0
   task automatic contention(input string nm);
      int got[4] = '{-1, -1, -1, -1};
      int ackc[4] = '{-1, -1, -1, -1};
      int ng = 0, na = 0, a0 = 0, a1 = 0;
      bit both = 0, wrong = 0, rd_ok = 1;
      sl_waits = 0; sl_err = 0;
      r0_addr = 32'h10; r0_write = 0; r0_strb = 0; r0_prot = 0;
      r1_addr = 32'h14; r1_write = 0; r1_strb = 0; r1_prot = 0;
      r0_req = 1; r1_req = 1;
      for (int n = 0; n < 40; n++) begin
         @(negedge PCLK);
         if (PSEL && !PENABLE && ng < 4) begin got[ng] = int'(grant_id); ng++; end
         if (r0_ack && r1_ack) both = 1;
         if (r0_ack) begin
            a0++;
            if (grant_id !== 1'b0) wrong = 1;
            if (r0_rdata !== ref_mem[4]) rd_ok = 0;
         end
         if (r1_ack) begin
            a1++;
            if (grant_id !== 1'b1) wrong = 1;
            if (r1_rdata !== ref_mem[5]) rd_ok = 0;
         end
         if ((r0_ack || r1_ack) && na < 4) begin ackc[na] = n; na++; end
         if (na == 4) break;
         @(posedge PCLK); #1;
      end
      @(posedge PCLK); #1;
      r0_req = 0; r1_req = 0;
      for (int i = 0; i < 4; i++) chk($sformatf("%s grant%0d", nm, i), got[i], i % 2);
      chk({nm, " first_ack"}, ackc[0], 3);
      for (int i = 1; i < 4; i++) chk($sformatf("%s ack_gap%0d", nm, i), ackc[i] - ackc[i-1], 4);
      chk({nm, " acks_r0"}, a0, 2);
      chk({nm, " acks_r1"}, a1, 2);
      chk({nm, " both_ack"}, both, 0);
      chk({nm, " ack_owner"}, wrong, 0);
      chk({nm, " rdata"}, rd_ok, 1);
      @(posedge PCLK); #1;
   endtask

   typedef struct {
      bit          id;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      int          waits;
      bit          serr;
      int          lat;
      logic [31:0] rdata;
      bit          err;
   } vec_t;

   initial begin
      vec_t tbl[12];
      tbl[0]  = '{0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0,  0, 3,  32'h0,        0};
      tbl[1]  = '{0, 0, 32'h10, 32'h0,        4'hF, 3'd2, 0,  0, 3,  32'hDEADBEEF, 0};
      tbl[2]  = '{1, 1, 32'h14, 32'h11223344, 4'h3, 3'd1, 3,  0, 6,  32'h0,        0};
      tbl[3]  = '{1, 0, 32'h14, 32'h0,        4'h0, 3'd0, 0,  0, 3,  32'h00003344, 0};
      tbl[4]  = '{0, 0, 32'h10, 32'h0,        4'h0, 3'd0, 1,  1, 4,  32'hDEADBEEF, 1};
      tbl[5]  = '{0, 0, 32'h10, 32'h0,        4'h0, 3'd5, 0,  0, 3,  32'hDEADBEEF, 0};
      tbl[6]  = '{1, 0, 32'h14, 32'h0,        4'h0, 3'd0, 99, 0, 19, 32'h0,        1};
      tbl[7]  = '{1, 0, 32'h14, 32'h0,        4'h0, 3'd0, 2,  0, 5,  32'h00003344, 0};
      tbl[8]  = '{0, 1, 32'h18, 32'hCAFEF00D, 4'hC, 3'd0, 0,  1, 3,  32'h0,        1};
      tbl[9]  = '{0, 0, 32'h18, 32'h0,        4'h0, 3'd0, 0,  0, 3,  32'h0,        0};
      tbl[10] = '{1, 1, 32'h1C, 32'h55AA55AA, 4'hF, 3'd7, 99, 0, 19, 32'h0,        1};
      tbl[11] = '{1, 0, 32'h1C, 32'h0,        4'h0, 3'd0, 4,  0, 7,  32'h0,        0};

      // reset state
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      chk("rst PSEL", PSEL, 0);       chk("rst PENABLE", PENABLE, 0);
      chk("rst PADDR", PADDR, 0);     chk("rst PWDATA", PWDATA, 0);
      chk("rst PPROT", PPROT, 0);     chk("rst PSTRB", PSTRB, 0);
      chk("rst PWRITE", PWRITE, 0);   chk("rst acks", {r0_ack, r1_ack}, 0);
      chk("rst r0_rdata", r0_rdata, 0); chk("rst r1_rdata", r1_rdata, 0);
      chk("rst errs", {r0_err, r1_err}, 0);
      chk("rst busy", busy, 0);       chk("rst grant_id", grant_id, 0);
      @(posedge PCLK); #1;
      PRESETn = 1;
      @(posedge PCLK); #1;

      contention("cont_reset");

      for (int i = 0; i < 12; i++)
         run_txn($sformatf("vec%0d", i), tbl[i].id, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                 tbl[i].strb, tbl[i].prot, tbl[i].waits, tbl[i].serr,
                 tbl[i].lat, tbl[i].rdata, tbl[i].err);

      // randomized transactions against the reference model
      for (int i = 0; i < 30; i++) begin
         bit          id  = 1'($urandom_range(0, 1));
         bit          wr  = 1'($urandom_range(0, 1));
         logic [31:0] a   = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
         logic [31:0] wd  = $urandom;
         logic [3:0]  st  = 4'($urandom_range(0, 15));
         logic [2:0]  pr  = 3'($urandom_range(0, 7));
         int          w   = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, 4));
         bit          se  = ($urandom_range(0, 5) == 0);
         bit          to  = (w > TO);
         run_txn($sformatf("rnd%0d", i), id, wr, a, wd, st, pr, w, se,
                 to ? TO + 3 : 3 + w,
                 (to || wr) ? 32'h0 : ref_mem[a[5:2]],
                 to || se);
      end

      // leave r0 as last grant, then abort an r0 read mid-ACCESS
      run_txn("pre_rst", 0, 0, 32'h10, 32'h0, 4'h0, 3'd0, 0, 0, 3, ref_mem[4], 0);
      sl_waits = 99; sl_err = 0;
      r0_addr = 32'h20; r0_write = 0; r0_strb = 0; r0_prot = 0; r0_req = 1;
      repeat (4) @(posedge PCLK);
      @(negedge PCLK);
      chk("mid penable_before", PENABLE, 1);
      #2;
      PRESETn = 0;
      r0_req  = 0;
      #1;
      chk("mid PSEL", PSEL, 0);
      chk("mid PENABLE", PENABLE, 0);
      chk("mid busy", busy, 0);
      chk("mid acks", {r0_ack, r1_ack}, 0);
      repeat (2) @(posedge PCLK);
      @(negedge PCLK);
      chk("mid acks_held", {r0_ack, r1_ack}, 0);
      @(posedge PCLK); #1;
      PRESETn = 1;
      contention("cont_after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
